// File: rtl/ped_req_ctrl.sv
// Pedestrian push-button request controller: synchronizes and debounces the
// button, raises a crossing request, then enforces a cooldown after the grant.
module ped_req_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned COOLDOWN_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       ack,
   output logic       req,
   output logic       busy,
   output logic [7:0] press_count
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      PENDING  = 3'd2,
      COOLDOWN = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic       btn_m;
   logic       btn_s;
   logic       accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         btn_m <= btn_raw;
         btn_s <= btn_m;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         press_count <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            press_count <= press_count + 8'd1;
         end
      end
   end

   // cnt is shared: debounce run length in DEBOUNCE, elapsed cycles in COOLDOWN
   always_comb begin
      state_nxt = IDLE;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt   = '0;
            state_nxt = btn_s ? DEBOUNCE : IDLE;
         end
         DEBOUNCE: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt = PENDING;
               accept    = 1'b1;
            end else begin
               state_nxt = DEBOUNCE;
               cnt_nxt   = cnt + 8'd1;
            end
         end
         PENDING: begin
            if (ack) begin
               state_nxt = COOLDOWN;
               cnt_nxt   = '0;
            end else begin
               state_nxt = PENDING;
            end
         end
         COOLDOWN: begin
            if (cnt == COOL_LAST) begin
               state_nxt = RELEASE;
            end else begin
               state_nxt = COOLDOWN;
               cnt_nxt   = cnt + 8'd1;
            end
         end
         RELEASE: begin
            state_nxt = btn_s ? RELEASE : IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign req  = (state == PENDING);
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ped_req_ctrl.sv
// Scoreboard bench for ped_req_ctrl: a cycle-level behavioural model predicts
// req transitions and per-cycle busy/press_count; a monitor pops and compares.
module tb_ped_req_ctrl;

   localparam int unsigned DEB  = 8;
   localparam int unsigned COOL = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_raw;
   logic       ack;
   logic       req;
   logic       busy;
   logic [7:0] press_count;

   always #5 clk = ~clk;

   ped_req_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .COOLDOWN_CYCLES(COOL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .ack        (ack),
      .req        (req),
      .busy       (busy),
      .press_count(press_count)
   );

   typedef struct {
      int cyc;
      bit lvl;
      int pc;
   } ev_t;

   typedef struct {
      bit busy;
      int pc;
   } st_t;

   ev_t ev_q[$];
   st_t st_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   int last_rise = -1;
   bit mon_prev;

   // model: two-sample button history, high-run length, pending flag,
   // waiting-for-release flag covering cooldown, cooldown end edge
   bit m_h1, m_h2, m_pend, m_wrel;
   int m_run, m_pc, m_cool_end;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_h1 = 0; m_h2 = 0; m_pend = 0; m_wrel = 0;
      m_run = 0; m_pc = 0; m_cool_end = -1;
   endtask

   // Called at a falling edge: drives inputs, predicts the coming rising edge.
   task automatic step(input bit b, input bit a);
      int e;
      bit bs;
      btn_raw = b;
      ack     = a;
      e  = cyc + 1;
      bs = m_h2;
      m_h2 = m_h1;
      m_h1 = b;
      if (m_pend) begin
         if (a) begin
            m_pend     = 0;
            m_wrel     = 1;
            m_cool_end = e + int'(COOL);
            ev_q.push_back('{e, 1'b0, m_pc});
         end
      end else if (m_wrel) begin
         if (e > m_cool_end && !bs) m_wrel = 0;
      end else if (bs) begin
         m_run++;
         if (m_run == int'(DEB) + 1) begin
            m_run  = 0;
            m_pend = 1;
            m_pc   = (m_pc + 1) % 256;
            ev_q.push_back('{e, 1'b1, m_pc});
         end
      end else begin
         m_run = 0;
      end
      st_q.push_back('{(m_pend || m_wrel || m_run > 0), m_pc});
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      reset   = 1'b1;
      btn_raw = 1'b0;
      ack     = 1'b0;
      #1;
      chk("async_reset_req", req, 0);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_count", press_count, 0);
      @(posedge clk);
      #2;
      ev_q.delete();
      st_q.delete();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // monitor
   initial begin
      ev_t ev;
      st_t st;
      mon_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mon_prev = 1'b0;
         end else begin
            if (st_q.size() == 0) begin
               chk("status_queue_size", st_q.size(), 1);
            end else begin
               st = st_q.pop_front();
               chk("busy", busy, st.busy);
               chk("press_count", press_count, st.pc);
            end
            if (req !== mon_prev) begin
               if (ev_q.size() == 0) begin
                  chk("unexpected_req_edge", req, mon_prev);
               end else begin
                  ev = ev_q.pop_front();
                  chk("req_level", req, ev.lvl);
                  chk("req_edge_cycle", cyc, ev.cyc);
                  chk("req_edge_count", press_count, ev.pc);
               end
               if (req === 1'b1) last_rise = cyc;
               mon_prev = req;
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int lvl;
      int len;
      reset   = 1'b1;
      btn_raw = 1'b0;
      ack     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_req", req, 0);
      chk("reset_busy", busy, 0);
      chk("reset_count", press_count, 0);
      reset = 1'b0;

      // clean press
      repeat (20) step(1, 0);
      chk("latency_edge", last_rise, DEB + 3);
      chk("clean_press_count", press_count, 1);
      chk("clean_press_req", req, 1);

      // grant, then a press inside cooldown must be ignored
      step(0, 1);
      chk("req_after_ack", req, 0);
      repeat (4) step(0, 0);
      repeat (8) step(1, 0);
      repeat (10) step(0, 0);
      chk("cooldown_press_count", press_count, 1);
      chk("cooldown_idle_busy", busy, 0);

      // bounce
      repeat (5) step(1, 0);
      step(0, 0);
      repeat (5) step(1, 0);
      repeat (6) step(0, 0);
      chk("bounce_count", press_count, 1);
      chk("bounce_busy", busy, 0);

      // held through ack and cooldown
      repeat (12) step(1, 0);
      chk("held_first_count", press_count, 2);
      step(1, 1);
      repeat (30) step(1, 0);
      chk("held_release_req", req, 0);
      chk("held_release_busy", busy, 1);
      chk("held_release_count", press_count, 2);
      repeat (4) step(0, 0);
      repeat (12) step(1, 0);
      chk("held_second_count", press_count, 3);
      step(0, 1);
      repeat (20) step(0, 0);

      // reset while pending, then a fresh debounce
      repeat (12) step(1, 0);
      chk("pending_before_reset", req, 1);
      do_reset();
      repeat (20) step(1, 0);
      chk("post_reset_latency", last_rise, DEB + 3);
      chk("post_reset_count", press_count, 1);
      step(0, 1);
      repeat (20) step(0, 0);

      // randomized
      repeat (80) begin
         lvl = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 14));
         repeat (len) step(lvl[0], m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
      end
      repeat (40) step(0, m_pend);

      // wrap
      do_reset();
      repeat (256) begin
         repeat (12) step(1, 0);
         step(0, 1);
         repeat (20) step(0, 0);
      end
      chk("wrap_256_count", press_count, 0);
      repeat (12) step(1, 0);
      step(0, 1);
      repeat (20) step(0, 0);
      chk("wrap_257_count", press_count, 1);

      chk("events_outstanding", ev_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ped_req_ctrl.md
PED_REQ_CTRL -- requirements
Module: ped_req_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, number of consecutive synchronized-high cycles required to accept a press; legal range 1..255.
REQ-002 Parameter COOLDOWN_CYCLES, default 16, number of cycles after ack during which presses are ignored; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port btn_raw  input  1  asynchronous, bouncy pedestrian push-button level.
REQ-006 Port ack  input  1  grant from the downstream traffic-light controller; walk phase has started.
REQ-007 Port req  output  1  registered pedestrian crossing request to the light controller.
REQ-008 Port busy  output  1  high whenever state is not IDLE.
REQ-009 Port press_count  output  8  count of accepted requests; wraps 255->0.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer to give btn_s; btn_s is the only form of the button used internally.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, PENDING, COOLDOWN and RELEASE, held in a 3-bit register; unused encodings SHALL return to IDLE on the next edge.
REQ-012 One 8-bit counter cnt SHALL serve both the DEBOUNCE and COOLDOWN states.
REQ-013 IDLE: cnt<=0; if btn_s=1 -> DEBOUNCE, else stay in IDLE.
REQ-014 DEBOUNCE: btn_s=0 -> IDLE with cnt<=0; btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> PENDING; otherwise cnt<=cnt+1.
REQ-015 On the DEBOUNCE->PENDING transition, press_count SHALL increment by 1 (modulo 256).
REQ-016 req SHALL be 1 exactly when state=PENDING, decoded from the state register with no combinational path from ack or btn_raw.
REQ-017 Latency: with btn_raw held high, req SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples btn_raw=1 as edge 1.
REQ-018 PENDING: req held; button activity ignored; ack=1 -> COOLDOWN with cnt<=0; req SHALL fall on that same edge.
REQ-019 ack SHALL be ignored in every state other than PENDING.
REQ-020 COOLDOWN: cnt<=cnt+1 each cycle; at cnt=COOLDOWN_CYCLES-1 -> RELEASE; presses ignored.
REQ-021 RELEASE: btn_s=0 -> IDLE; btn_s=1 -> stay, so a held button never produces a second request.
REQ-022 Simultaneous ack and btn_s changes SHALL follow the per-state rules above; ack has no effect outside PENDING.
REQ-023 busy SHALL be registered-state decode: 0 in IDLE, 1 in all other states.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, cnt=0, both synchronizer flops=0 and press_count=0, giving req=0 and busy=0 without waiting for a clock edge.
REQ-025 Reset in any state, including PENDING, SHALL drop req asynchronously; after release, the block SHALL require a fresh full debounce before any new request.

Verification
REQ-026 Clean press (defaults): reset low, btn_raw high for 20 cycles -> req=1 from edge 11, press_count=1, busy=1 from edge 3.
REQ-027 Bounce: btn_raw high 5 cycles, low 1 cycle, high 5 cycles, then low -> req never asserts, press_count=0, state back to IDLE.
REQ-028 Grant and cooldown: in PENDING assert ack for 1 cycle, release button, press again during cooldown -> req falls on the ack edge, busy=1 for 16 cooldown cycles plus release, no new req until a press after IDLE.
REQ-029 Held button: keep btn_raw high through ack and the whole cooldown -> state holds in RELEASE, req stays 0, press_count unchanged; release then press again -> second req, press_count=2.
REQ-030 Reset mid-PENDING: assert reset between clock edges -> req, busy and press_count read 0 before the next edge.
REQ-031 Wrap: 256 accepted press/ack cycles -> press_count reads 0; one more -> reads 1.
